// File: rtl/btb_next_pc.sv
// Fetch-stage next-PC generator: fetch PC register plus a direct-mapped BTB.
// The BTB is indexed by pc[IDX_W+1:2]. It is written only by taken resolutions
// and is read combinationally on the current fetch PC.
module btb_next_pc #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned IDX_W    = 4,
  parameter int unsigned TAG_W    = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_fire,
  input  logic        prdt_br,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic [31:0] upd_target,
  input  logic        upd_taken,
  input  logic        upd_jump,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc,
  output logic [31:0] next_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  output logic        btb_hit
);

  localparam int unsigned Entries = 2 ** IDX_W;

  logic [31:0]        pc_q, pc_d;
  logic [Entries-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q    [Entries];
  logic [TAG_W-1:0]   tag_d    [Entries];
  logic [31:0]        target_q [Entries];
  logic [31:0]        target_d [Entries];
  logic [Entries-1:0] jump_q, jump_d;

  logic [IDX_W-1:0] idx, upd_idx;
  logic [TAG_W-1:0] tag, upd_tag;

  // Low two bits of the update PC never take part in indexing or tagging.
  logic unused_upd_lsb;
  assign unused_upd_lsb = ^upd_pc[1:0];

  assign idx     = pc_q[IDX_W+1:2];
  assign tag     = pc_q[31:IDX_W+2];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[31:IDX_W+2];

  // Lookup on the current PC; sees pre-update contents (no write bypass).
  always_comb begin
    btb_hit     = valid_q[idx] && (tag_q[idx] == tag);
    pred_target = target_q[idx];
    pred_taken  = btb_hit && (jump_q[idx] || prdt_br);
    next_pc     = pred_taken ? pred_target : (pc_q + 32'd4);
    pc          = pc_q;
  end

  // Next fetch PC: redirect beats the predicted path; otherwise hold on stall.
  always_comb begin
    pc_d = pc_q;
    if (redirect) begin
      pc_d = redirect_pc;
    end else if (fetch_fire) begin
      pc_d = next_pc;
    end
  end

  // BTB write: only taken resolutions allocate, replacing whatever was there.
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    jump_d   = jump_q;
    if (upd_valid && upd_taken) begin
      valid_d[upd_idx]  = 1'b1;
      tag_d[upd_idx]    = upd_tag;
      target_d[upd_idx] = upd_target;
      jump_d[upd_idx]   = upd_jump;
    end
  end

  // PC and valid bits are reset; reset overrides redirect, fetch and update.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      valid_q <= '0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  // Payload arrays carry no reset; stale data is masked by the valid bits.
  always_ff @(posedge clk) begin
    tag_q    <= tag_d;
    target_q <= target_d;
    jump_q   <= jump_d;
  end

endmodule

// File: tb/tb_btb_next_pc.sv
// Self-checking bench for btb_next_pc: a reference model predicts the PC after
// each edge (queued, popped after the edge), plus directed constant checks.
module tb_btb_next_pc;

  logic        clk = 1'b0;
  logic        rst, fetch_fire, prdt_br, upd_valid, upd_taken, upd_jump, redirect;
  logic [31:0] upd_pc, upd_target, redirect_pc;
  logic [31:0] pc, next_pc, pred_target;
  logic        pred_taken, btb_hit;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [31:0] exp_q [$];

  // Reference model state (IDX_W = 4: idx = pc[5:2], tag = pc[31:6]).
  logic [31:0] m_pc;
  logic [15:0] m_valid;
  logic [25:0] m_tag [16];
  logic [31:0] m_tgt [16];
  logic [15:0] m_jmp;
  bit          m_known = 0;

  btb_next_pc #(
    .RESET_PC(32'h0000_0000),
    .IDX_W   (4),
    .TAG_W   (26)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fetch_fire (fetch_fire),
    .prdt_br    (prdt_br),
    .upd_valid  (upd_valid),
    .upd_pc     (upd_pc),
    .upd_target (upd_target),
    .upd_taken  (upd_taken),
    .upd_jump   (upd_jump),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .pc         (pc),
    .next_pc    (next_pc),
    .pred_taken (pred_taken),
    .pred_target(pred_target),
    .btb_hit    (btb_hit)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, check model-predicted combinational outputs,
  // queue the expected post-edge PC, then pop and compare it after the edge.
  task automatic step(input logic r, input logic ff, input logic br,
                      input logic uv, input logic [31:0] upc, input logic [31:0] utgt,
                      input logic ut, input logic uj,
                      input logic rd, input logic [31:0] rpc);
    logic [3:0]  i;
    logic        hit, tkn;
    logic [31:0] nxt, e;
    rst = r; fetch_fire = ff; prdt_br = br; upd_valid = uv; upd_pc = upc;
    upd_target = utgt; upd_taken = ut; upd_jump = uj; redirect = rd; redirect_pc = rpc;
    #1;
    i   = m_pc[5:2];
    hit = m_valid[i] && (m_tag[i] == m_pc[31:6]);
    tkn = hit && (m_jmp[i] || br);
    nxt = tkn ? m_tgt[i] : m_pc + 32'd4;
    if (m_known) begin
      check("pc_now", pc, m_pc);
      check("btb_hit", {31'd0, btb_hit}, {31'd0, hit});
      check("pred_taken", {31'd0, pred_taken}, {31'd0, tkn});
      check("next_pc", next_pc, nxt);
    end
    if (r)       exp_q.push_back(32'h0);
    else if (rd) exp_q.push_back(rpc);
    else if (ff) exp_q.push_back(nxt);
    else         exp_q.push_back(m_pc);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("pc_after_edge", pc, e);
    m_pc = e;
    if (r) begin
      m_valid = '0;
      m_known = 1;
    end else if (uv && ut) begin
      m_valid[upc[5:2]] = 1'b1;
      m_tag[upc[5:2]]   = upc[31:6];
      m_tgt[upc[5:2]]   = utgt;
      m_jmp[upc[5:2]]   = uj;
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 0; fetch_fire = 0; prdt_br = 0; upd_valid = 0; upd_taken = 0; upd_jump = 0;
    redirect = 0; upd_pc = '0; upd_target = '0; redirect_pc = '0;
    m_pc = '0; m_valid = '0; m_jmp = '0;
    @(negedge clk);

    // Reset for two cycles.
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    prdt_br = 0; rst = 0; #1;
    check("rst_pc", pc, 32'h0);
    check("rst_hit", {31'd0, btb_hit}, 32'd0);
    check("rst_taken", {31'd0, pred_taken}, 32'd0);
    check("rst_next", next_pc, 32'h4);

    // Sequential fetch 0x4, 0x8, 0xC.
    repeat (3) step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("seq_pc", pc, 32'hC);

    // Train 0x10 -> 0x80 while fetching into 0x10.
    step(0, 1, 0, 1, 32'h10, 32'h80, 1, 0, 0, 0);
    prdt_br = 1; #1;
    check("train_hit", {31'd0, btb_hit}, 32'd1);
    check("train_taken", {31'd0, pred_taken}, 32'd1);
    check("train_next", next_pc, 32'h80);
    check("train_target", pred_target, 32'h80);
    prdt_br = 0; #1;
    check("nt_next", next_pc, 32'h14);
    check("nt_taken", {31'd0, pred_taken}, 32'd0);
    step(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    check("taken_pc", pc, 32'h80);

    // Redirect beats fetch_fire; redirect also works while stalled.
    step(0, 1, 1, 0, 0, 0, 0, 0, 1, 32'h14);
    check("redir_ff_pc", pc, 32'h14);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h14);
    check("redir_stall_pc", pc, 32'h14);

    // Jump entry predicts taken regardless of prdt_br.
    step(0, 0, 0, 1, 32'h20, 32'h200, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h20);
    prdt_br = 0; #1;
    check("jump_taken", {31'd0, pred_taken}, 32'd1);
    check("jump_next", next_pc, 32'h200);

    // Look up 0x50 (aliases 0x10) while training it: hit only afterwards.
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h50);
    step(0, 0, 1, 1, 32'h50, 32'h90, 1, 0, 0, 0);
    check("alias_new_hit", {31'd0, btb_hit}, 32'd1);
    check("alias_new_tgt", pred_target, 32'h90);

    // Not-taken update leaves the entry alone.
    step(0, 0, 1, 1, 32'h50, 32'h444, 0, 1, 0, 0);
    check("nt_upd_hit", {31'd0, btb_hit}, 32'd1);
    check("nt_upd_tgt", pred_target, 32'h90);

    // Stall three cycles.
    repeat (3) step(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    check("stall_pc", pc, 32'h50);

    // 0x10 was overwritten by its alias.
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h10);
    check("alias_old_hit", {31'd0, btb_hit}, 32'd0);

    // PC+4 wraps at the top of the address space.
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC);
    check("wrap_hit", {31'd0, btb_hit}, 32'd0);
    check("wrap_next", next_pc, 32'h0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("wrap_pc", pc, 32'h0);

    // Reset wins over redirect, fetch and update; valid bits cleared.
    step(1, 1, 1, 1, 32'h10, 32'h80, 1, 0, 1, 32'h40);
    rst = 0; redirect = 0; upd_valid = 0; #1;
    check("rst2_pc", pc, 32'h0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h20);
    check("rst2_hit", {31'd0, btb_hit}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
